// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker: receive-side checker for the 48-bit PRBS link.
// Hunts for the start pattern, regenerates the transmitter's stream with two
// 24-bit Fibonacci LFSRs (taps 24,23,22,17), and accumulates word, errored-word
// and bit-error counts plus marker-to-start-pattern latency.
module prbs_rx_checker #(
    parameter logic [47:0] start_pattern = 48'hFFFFFF000000,
    parameter logic [23:0] fill_a        = 24'h83B62E,
    parameter logic [23:0] fill_b        = 24'hE26B38,
    parameter int unsigned LOSS_THR      = 8,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned LAT_W         = 16
) (
    input  logic              GEN_CLK,
    input  logic              RST,
    input  logic [47:0]       PRBS_IN,
    input  logic              STRT_LTNCY_IN,
    input  logic              CLR_CNT,
    output logic              LOCKED,
    output logic              ERR,
    output logic              LOCK_LOST,
    output logic [CNT_W-1:0]  WORDS,
    output logic [CNT_W-1:0]  ERR_WORDS,
    output logic [CNT_W-1:0]  ERR_BITS,
    output logic [LAT_W-1:0]  LATENCY,
    output logic              LAT_VALID
);

    localparam int unsigned WORD_W = 48;
    localparam int unsigned HALF_W = 24;
    localparam int unsigned POP_W  = 6;
    localparam int unsigned RUN_W  = 8;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HALF_W-1:0] lfsr_a;
    logic [HALF_W-1:0] lfsr_b;
    logic [RUN_W-1:0]  err_run;

    logic [WORD_W-1:0] diff_q;
    logic              diff_vld;

    logic              lat_run;
    logic [LAT_W-1:0]  lat_cnt;

    logic [WORD_W-1:0] exp_c;
    logic [WORD_W-1:0] diff_c;
    logic              diff_nz_c;
    logic              start_hit_c;
    logic              chk_c;
    logic              lfsr_load_c;
    logic              lfsr_adv_c;
    logic              lose_c;
    logic [RUN_W-1:0]  run_inc_c;
    logic [POP_W-1:0]  pop_c;
    logic [CNT_W:0]    bits_sum_c;
    logic              marker_c;

    // One Fibonacci step of lfsr_R24: feedback from taps 24,23,22,17
    function automatic logic [HALF_W-1:0] lfsr_step(input logic [HALF_W-1:0] q);
        return {q[HALF_W-2:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
    endfunction

    // Number of set bits in a 48-bit word (0..48)
    function automatic logic [POP_W-1:0] popcnt48(input logic [WORD_W-1:0] v);
        logic [POP_W-1:0] s;
        s = '0;
        for (int i = 0; i < WORD_W; i++) begin
            s = s + POP_W'(v[i]);
        end
        return s;
    endfunction

    // Word compare against the locally regenerated stream
    always_comb begin
        exp_c       = {lfsr_a, lfsr_b};
        diff_c      = PRBS_IN ^ exp_c;
        diff_nz_c   = |diff_c;
        start_hit_c = (PRBS_IN == start_pattern);
        run_inc_c   = err_run + RUN_W'(1);
        marker_c    = ~STRT_LTNCY_IN;
    end

    // State register
    always_ff @(posedge GEN_CLK) begin
        if (RST) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and LFSR control: HUNT holds the fills, CHECK advances them
    always_comb begin
        state_nxt   = state;
        chk_c       = 1'b0;
        lfsr_load_c = 1'b0;
        lfsr_adv_c  = 1'b0;
        lose_c      = 1'b0;
        case (state)
            HUNT: begin
                lfsr_load_c = 1'b1;
                if (start_hit_c) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (start_hit_c) begin
                    // re-align: reload fills, word is neither counted nor errored
                    lfsr_load_c = 1'b1;
                end else begin
                    chk_c      = 1'b1;
                    lfsr_adv_c = 1'b1;
                    if (diff_nz_c && (run_inc_c == RUN_W'(LOSS_THR))) begin
                        lose_c    = 1'b1;
                        state_nxt = HUNT;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // Local LFSR pair, upper half lfsr_a and lower half lfsr_b
    always_ff @(posedge GEN_CLK) begin
        if (RST || lfsr_load_c) begin
            lfsr_a <= fill_a;
            lfsr_b <= fill_b;
        end else if (lfsr_adv_c) begin
            lfsr_a <= lfsr_step(lfsr_a);
            lfsr_b <= lfsr_step(lfsr_b);
        end
    end

    // Consecutive errored-word run; any clean or uncounted word breaks it
    always_ff @(posedge GEN_CLK) begin
        if (RST) begin
            err_run <= '0;
        end else if (chk_c && diff_nz_c && !lose_c) begin
            err_run <= run_inc_c;
        end else begin
            err_run <= '0;
        end
    end

    // First pipeline stage: DIFF capture, per-word ERR flag and LOCKED
    always_ff @(posedge GEN_CLK) begin
        if (RST) begin
            diff_q   <= '0;
            diff_vld <= 1'b0;
            ERR      <= 1'b0;
            LOCKED   <= 1'b0;
        end else begin
            diff_q   <= diff_c;
            diff_vld <= chk_c;
            ERR      <= chk_c && diff_nz_c;
            LOCKED   <= (state_nxt == CHECK);
        end
    end

    // Popcount of the captured DIFF and saturating bit-error sum
    always_comb begin
        pop_c      = popcnt48(diff_q);
        bits_sum_c = {1'b0, ERR_BITS} + (CNT_W + 1)'(pop_c);
    end

    // Second pipeline stage: saturating counters, clear wins over update
    always_ff @(posedge GEN_CLK) begin
        if (RST || CLR_CNT) begin
            WORDS     <= '0;
            ERR_WORDS <= '0;
            ERR_BITS  <= '0;
        end else if (diff_vld) begin
            if (WORDS != '1) begin
                WORDS <= WORDS + CNT_W'(1);
            end
            if ((|diff_q) && (ERR_WORDS != '1)) begin
                ERR_WORDS <= ERR_WORDS + CNT_W'(1);
            end
            ERR_BITS <= bits_sum_c[CNT_W] ? '1 : bits_sum_c[CNT_W-1:0];
        end
    end

    // Sticky lock-loss flag
    always_ff @(posedge GEN_CLK) begin
        if (RST || CLR_CNT) begin
            LOCK_LOST <= 1'b0;
        end else if (lose_c) begin
            LOCK_LOST <= 1'b1;
        end
    end

    // Free-running latency counter, started by the marker, stopped by start pattern
    always_ff @(posedge GEN_CLK) begin
        if (RST) begin
            lat_run <= 1'b0;
            lat_cnt <= '0;
        end else if (marker_c) begin
            lat_cnt <= '0;
            lat_run <= !start_hit_c;
        end else if (lat_run) begin
            if (start_hit_c) begin
                lat_run <= 1'b0;
            end else if (lat_cnt != '1) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
        end
    end

    // Latency result: captured when the start pattern ends a running count
    always_ff @(posedge GEN_CLK) begin
        if (RST || CLR_CNT) begin
            LATENCY   <= '0;
            LAT_VALID <= 1'b0;
        end else if (marker_c) begin
            if (start_hit_c) begin
                LATENCY   <= '0;
                LAT_VALID <= 1'b1;
            end else begin
                LAT_VALID <= 1'b0;
            end
        end else if (lat_run && start_hit_c) begin
            LATENCY   <= (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);
            LAT_VALID <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Directed bench for prbs_rx_checker with a behavioural transmitter model
// (start pattern, then the two-LFSR stream) and an optional delay line.
module tb_prbs_rx_checker;

    localparam logic [47:0] START  = 48'hFFFFFF000000;
    localparam logic [23:0] FILL_A = 24'h83B62E;
    localparam logic [23:0] FILL_B = 24'hE26B38;
    localparam logic [47:0] INJ    = 48'h608000400100;

    logic        GEN_CLK;
    logic        RST;
    logic [47:0] PRBS_IN;
    logic        STRT_LTNCY_IN;
    logic        CLR_CNT;
    logic        LOCKED;
    logic        ERR;
    logic        LOCK_LOST;
    logic [31:0] WORDS;
    logic [31:0] ERR_WORDS;
    logic [31:0] ERR_BITS;
    logic [15:0] LATENCY;
    logic        LAT_VALID;

    int n_pass;
    int n_total;

    logic [23:0] tx_a;
    logic [23:0] tx_b;
    bit          tx_start_pend;
    bit          tx_mark_pend;
    int          dly;
    logic [47:0] dl [0:7];

    prbs_rx_checker dut (
        .GEN_CLK       (GEN_CLK),
        .RST           (RST),
        .PRBS_IN       (PRBS_IN),
        .STRT_LTNCY_IN (STRT_LTNCY_IN),
        .CLR_CNT       (CLR_CNT),
        .LOCKED        (LOCKED),
        .ERR           (ERR),
        .LOCK_LOST     (LOCK_LOST),
        .WORDS         (WORDS),
        .ERR_WORDS     (ERR_WORDS),
        .ERR_BITS      (ERR_BITS),
        .LATENCY       (LATENCY),
        .LAT_VALID     (LAT_VALID)
    );

    initial GEN_CLK = 1'b0;
    always #5 GEN_CLK = ~GEN_CLK;

    function automatic logic [23:0] lfsr_next(input logic [23:0] q);
        return {q[22:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
    endfunction

    // Apply one clock of inputs; outputs are sampled 1ns after the edge
    task automatic drive(input logic [47:0] w, input logic mk_n, input logic clr, input logic rst);
        PRBS_IN       = w;
        STRT_LTNCY_IN = mk_n;
        CLR_CNT       = clr;
        RST           = rst;
        @(posedge GEN_CLK);
        #1;
    endtask

    task automatic tx_reset(input bit with_marker);
        tx_a          = FILL_A;
        tx_b          = FILL_B;
        tx_start_pend = 1'b1;
        tx_mark_pend  = with_marker;
    endtask

    // One transmitter clock through the delay line; marker is undelayed
    task automatic tx_cycle(input logic [47:0] inj, input logic clr);
        logic [47:0] w;
        logic [47:0] o;
        logic        mk_n;
        mk_n = 1'b1;
        if (tx_start_pend) begin
            w             = START;
            mk_n          = !tx_mark_pend;
            tx_start_pend = 1'b0;
        end else begin
            w    = {tx_a, tx_b};
            tx_a = lfsr_next(tx_a);
            tx_b = lfsr_next(tx_b);
        end
        if (dly == 0) o = w;
        else          o = dl[dly-1];
        for (int i = 7; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = w;
        drive(o ^ inj, mk_n, clr, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(48'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) dl[i] = 48'h0;
    endtask

    task automatic test_reset();
        do_reset(10);
        n_total++; if (LOCKED !== 1'b0) $display("FAIL reset_locked: got %0b expected 0", LOCKED); else n_pass++;
        n_total++; if (ERR !== 1'b0) $display("FAIL reset_err: got %0b expected 0", ERR); else n_pass++;
        n_total++; if (WORDS !== 32'd0) $display("FAIL reset_words: got %0d expected 0", WORDS); else n_pass++;
        n_total++; if (LAT_VALID !== 1'b0 || LATENCY !== 16'd0) $display("FAIL reset_latency: got %0d/%0b expected 0/0", LATENCY, LAT_VALID); else n_pass++;
        n_total++; if (LOCK_LOST !== 1'b0) $display("FAIL reset_lock_lost: got %0b expected 0", LOCK_LOST); else n_pass++;
    endtask

    // Direct connection: marker and start pattern in the same clock
    task automatic test_lock_direct();
        dly = 0;
        tx_reset(1'b1);
        for (int i = 0; i < 1000; i++) tx_cycle(48'h0, 1'b0);
        n_total++; if (LOCKED !== 1'b1) $display("FAIL direct_locked: got %0b expected 1", LOCKED); else n_pass++;
        n_total++; if (LATENCY !== 16'd0 || LAT_VALID !== 1'b1) $display("FAIL direct_latency: got %0d/%0b expected 0/1", LATENCY, LAT_VALID); else n_pass++;
        n_total++; if (ERR_WORDS !== 32'd0 || ERR_BITS !== 32'd0) $display("FAIL direct_errors: got %0d/%0d expected 0/0", ERR_WORDS, ERR_BITS); else n_pass++;
        // 999 words follow the start pattern; the last one is still in the pipe
        n_total++; if (WORDS !== 32'd998) $display("FAIL direct_words: got %0d expected 998", WORDS); else n_pass++;
    endtask

    // Five-register delay on the data only
    task automatic test_lock_delayed();
        do_reset(10);
        dly = 5;
        tx_reset(1'b1);
        for (int i = 0; i < 200; i++) tx_cycle(48'h0, 1'b0);
        n_total++; if (LATENCY !== 16'd5 || LAT_VALID !== 1'b1) $display("FAIL delayed_latency: got %0d/%0b expected 5/1", LATENCY, LAT_VALID); else n_pass++;
        n_total++; if (LOCKED !== 1'b1) $display("FAIL delayed_locked: got %0b expected 1", LOCKED); else n_pass++;
        n_total++; if (ERR_WORDS !== 32'd0) $display("FAIL delayed_err_words: got %0d expected 0", ERR_WORDS); else n_pass++;
        n_total++; if (WORDS !== 32'd193) $display("FAIL delayed_words: got %0d expected 193", WORDS); else n_pass++;
    endtask

    // Single-word injection of a 5-bit mask
    task automatic test_single_error();
        tx_cycle(48'h0, 1'b1);
        n_total++; if (ERR !== 1'b0) $display("FAIL single_err_before: got %0b expected 0", ERR); else n_pass++;
        tx_cycle(INJ, 1'b0);
        n_total++; if (ERR !== 1'b1) $display("FAIL single_err_pulse: got %0b expected 1", ERR); else n_pass++;
        tx_cycle(48'h0, 1'b0);
        n_total++; if (ERR !== 1'b0) $display("FAIL single_err_after: got %0b expected 0", ERR); else n_pass++;
        n_total++; if (ERR_WORDS !== 32'd1) $display("FAIL single_err_words: got %0d expected 1", ERR_WORDS); else n_pass++;
        n_total++; if (ERR_BITS !== 32'd5) $display("FAIL single_err_bits: got %0d expected 5", ERR_BITS); else n_pass++;
        n_total++; if (LOCKED !== 1'b1) $display("FAIL single_locked: got %0b expected 1", LOCKED); else n_pass++;
    endtask

    // Eight errored words drop lock; re-lock keeps LOCK_LOST until cleared
    task automatic test_lock_loss();
        tx_cycle(48'h0, 1'b1);
        for (int i = 0; i < 7; i++) tx_cycle(INJ, 1'b0);
        n_total++; if (LOCKED !== 1'b1) $display("FAIL loss_locked_at_7: got %0b expected 1", LOCKED); else n_pass++;
        tx_cycle(INJ, 1'b0);
        n_total++; if (LOCKED !== 1'b0 || LOCK_LOST !== 1'b1) $display("FAIL loss_flags: got locked=%0b lost=%0b expected 0/1", LOCKED, LOCK_LOST); else n_pass++;
        tx_cycle(48'h0, 1'b0);
        n_total++; if (ERR_WORDS !== 32'd8 || ERR_BITS !== 32'd40) $display("FAIL loss_counts: got %0d/%0d expected 8/40", ERR_WORDS, ERR_BITS); else n_pass++;
        tx_reset(1'b1);
        for (int i = 0; i < 20; i++) tx_cycle(48'h0, 1'b0);
        n_total++; if (LOCKED !== 1'b1 || LOCK_LOST !== 1'b1) $display("FAIL relock_flags: got locked=%0b lost=%0b expected 1/1", LOCKED, LOCK_LOST); else n_pass++;
        n_total++; if (ERR_WORDS !== 32'd8 || LATENCY !== 16'd5) $display("FAIL relock_counts: got errw=%0d lat=%0d expected 8/5", ERR_WORDS, LATENCY); else n_pass++;
        tx_cycle(48'h0, 1'b1);
        n_total++; if (LOCK_LOST !== 1'b0 || LOCKED !== 1'b1) $display("FAIL clear_lock_lost: got lost=%0b locked=%0b expected 0/1", LOCK_LOST, LOCKED); else n_pass++;
    endtask

    // Clear lands on the same edge as the errored word's counter update
    task automatic test_clear_collision();
        tx_cycle(INJ, 1'b0);
        tx_cycle(48'h0, 1'b1);
        n_total++; if (WORDS !== 32'd0 || ERR_WORDS !== 32'd0 || ERR_BITS !== 32'd0) $display("FAIL collide_counts: got %0d/%0d/%0d expected 0/0/0", WORDS, ERR_WORDS, ERR_BITS); else n_pass++;
        n_total++; if (LOCKED !== 1'b1) $display("FAIL collide_locked: got %0b expected 1", LOCKED); else n_pass++;
        tx_cycle(48'h0, 1'b0);
        n_total++; if (WORDS !== 32'd1 || ERR_WORDS !== 32'd0) $display("FAIL collide_resume: got %0d/%0d expected 1/0", WORDS, ERR_WORDS); else n_pass++;
    endtask

    // Start pattern mid-CHECK without a marker: re-align, not counted
    task automatic test_realign();
        tx_cycle(48'h0, 1'b1);
        tx_reset(1'b0);
        for (int i = 0; i < 10; i++) tx_cycle(48'h0, 1'b0);
        n_total++; if (WORDS !== 32'd9) $display("FAIL realign_words: got %0d expected 9", WORDS); else n_pass++;
        n_total++; if (ERR_WORDS !== 32'd0 || LOCKED !== 1'b1) $display("FAIL realign_clean: got errw=%0d locked=%0b expected 0/1", ERR_WORDS, LOCKED); else n_pass++;
        n_total++; if (LAT_VALID !== 1'b0 || LATENCY !== 16'd0) $display("FAIL realign_latency: got %0d/%0b expected 0/0", LATENCY, LAT_VALID); else n_pass++;
    endtask

    // Random non-start data never locks; reset mid-CHECK clears everything
    task automatic test_hunt_and_reset();
        logic [47:0] w;
        do_reset(2);
        for (int i = 0; i < 100; i++) begin
            w = {16'($urandom), $urandom};
            if (w == START) w = w ^ 48'h1;
            drive(w, 1'b1, 1'b0, 1'b0);
        end
        n_total++; if (LOCKED !== 1'b0) $display("FAIL random_locked: got %0b expected 0", LOCKED); else n_pass++;
        n_total++; if (WORDS !== 32'd0 || ERR_WORDS !== 32'd0 || ERR_BITS !== 32'd0) $display("FAIL random_counts: got %0d/%0d/%0d expected 0/0/0", WORDS, ERR_WORDS, ERR_BITS); else n_pass++;
        dly = 0;
        tx_reset(1'b1);
        for (int i = 0; i < 50; i++) tx_cycle(48'h0, 1'b0);
        n_total++; if (LOCKED !== 1'b1 || WORDS !== 32'd48) $display("FAIL prereset_lock: got locked=%0b words=%0d expected 1/48", LOCKED, WORDS); else n_pass++;
        drive({tx_a, tx_b}, 1'b1, 1'b0, 1'b1);
        n_total++; if (LOCKED !== 1'b0 || ERR !== 1'b0) $display("FAIL midreset_flags: got locked=%0b err=%0b expected 0/0", LOCKED, ERR); else n_pass++;
        n_total++; if (WORDS !== 32'd0 || LATENCY !== 16'd0 || LAT_VALID !== 1'b0) $display("FAIL midreset_counts: got words=%0d lat=%0d valid=%0b expected 0/0/0", WORDS, LATENCY, LAT_VALID); else n_pass++;
        for (int i = 0; i < 20; i++) tx_cycle(48'h0, 1'b0);
        n_total++; if (LOCKED !== 1'b0 || WORDS !== 32'd0) $display("FAIL postreset_hunt: got locked=%0b words=%0d expected 0/0", LOCKED, WORDS); else n_pass++;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        dly           = 0;
        tx_start_pend = 1'b0;
        tx_mark_pend  = 1'b0;
        tx_a          = FILL_A;
        tx_b          = FILL_B;
        RST           = 1'b1;
        PRBS_IN       = 48'h0;
        STRT_LTNCY_IN = 1'b1;
        CLR_CNT       = 1'b0;
        for (int i = 0; i < 8; i++) dl[i] = 48'h0;

        test_reset();
        test_lock_direct();
        test_lock_delayed();
        test_single_error();
        test_lock_loss();
        test_clear_collision();
        test_realign();
        test_hunt_and_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
